contention_controller: RTL
==========================

CONTENTION_CONTROLLER -- requirements
Module: contention_controller

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Rst  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 LpTxEn  input  1  high while the lane's LP transmitter owns the A/B/C wires.
REQ-004 ErrContentionP0  input  1  combinational LP contention indication, driven-low case, from the contention detector.
REQ-005 ErrContentionP1  input  1  combinational LP contention indication, driven-high case, from the contention detector.
REQ-006 CfgBlankCycles  input  4  cycles after LpTxEn rise during which contention inputs are ignored (driver settling).
REQ-007 CfgFilterCycles  input  4  consecutive cycles contention must persist to be confirmed; 0 treated as 1.
REQ-008 CfgHoldCycles  input  8  minimum cycles drivers stay released after confirmation.
REQ-009 ErrClear  input  1  single-cycle pulse clearing sticky flags and event counter.
REQ-010 LpDrvDisable  output  1  forces LP drivers to high-Z; high only in RELEASE.
REQ-011 ContentionIrq  output  1  one-cycle pulse on each confirmed contention.
REQ-012 ErrContentionP0Sticky  output  1  latched P0 contention flag.
REQ-013 ErrContentionP1Sticky  output  1  latched P1 contention flag.
REQ-014 ContentionCount  output  8  saturating count of confirmed contentions.
REQ-015 State  output  3  current FSM state: IDLE=0, BLANK=1, MONITOR=2, FILTER=3, RELEASE=4.

Function
REQ-016 All outputs SHALL be registered; inputs are sampled at each rising Clk edge.
REQ-017 IDLE: LpTxEn=1 -> BLANK with blank counter cleared if CfgBlankCycles>0, else -> MONITOR; contention inputs ignored in IDLE.
REQ-018 BLANK: counter increments each cycle; contention ignored; after exactly CfgBlankCycles cycles in BLANK -> MONITOR; LpTxEn=0 -> IDLE (takes priority).
REQ-019 MONITOR: LpTxEn=0 -> IDLE; else (P0|P1)=1 -> RELEASE if effective filter=1, otherwise -> FILTER with filter count=1; P0/P1 seen this cycle captured into a pending-type register.
REQ-020 FILTER: LpTxEn=0 -> IDLE (pending discarded); (P0|P1)=0 -> MONITOR (count and pending cleared); else count+1 and pending |= {P1,P0}; when count+1 equals effective filter -> RELEASE.
REQ-021 Confirmation SHALL occur on the transition into RELEASE: ContentionIrq=1 for that single cycle, sticky flags |= pending (including the confirming cycle's P0/P1), ContentionCount+1 saturating at 255, hold counter loaded with CfgHoldCycles.
REQ-022 RELEASE: LpDrvDisable=1; hold counter decrements to 0 and stops; exit -> IDLE only when hold counter=0 and LpTxEn=0; contention inputs ignored.
REQ-023 Latency: contention asserted continuously from MONITOR cycle N SHALL produce LpDrvDisable=1 and ContentionIrq=1 at cycle N+F, where F = effective filter cycles.
REQ-024 ErrClear SHALL clear sticky flags and ContentionCount next cycle; a simultaneous confirmation wins (flags set to new pending, count=1).
REQ-025 Configuration inputs SHALL be held stable while State != IDLE; a change mid-operation yields unspecified timing but no illegal state.
REQ-026 Unused State encodings 5-7 SHALL return to IDLE on the next cycle.

Reset
REQ-027 Rst=1 SHALL force State=IDLE, LpDrvDisable=0, ContentionIrq=0, both sticky flags=0, ContentionCount=0, and all internal counters and pending bits to 0, on the next edge.
REQ-028 Rst asserted during RELEASE SHALL deassert LpDrvDisable on the next edge regardless of hold counter.

Verification
REQ-029 Blank=2, Filter=3, Hold=4; LpTxEn rises, P1 high from first cycle onward -> BLANK 2 cycles, MONITOR, FILTER 2 cycles, Irq pulse and LpDrvDisable=1 three cycles after MONITOR entry, P1Sticky=1, Count=1.
REQ-030 Filter=3; P0 high 2 cycles then low -> FILTER then MONITOR, no Irq, Sticky=0, Count unchanged.
REQ-031 Hold=4, LpTxEn dropped 1 cycle after confirmation -> LpDrvDisable stays high exactly 4 cycles, then IDLE; with LpTxEn held high for 10 cycles -> stays RELEASE until LpTxEn=0.
REQ-032 Filter=0, P0 and P1 alternating -> immediate RELEASE next cycle, flags set per captured types; 256 confirmations -> Count saturates at 255.
REQ-033 ErrClear coincident with confirmation -> Count=1, flags equal new pending; ErrClear alone -> Count=0, flags 0.
REQ-034 Rst pulsed in FILTER and in RELEASE -> all outputs 0, State=IDLE on next cycle.

Source files
------------

// File: rtl/contention_controller_if.sv
// LP contention controller bus: detector inputs, configuration and status.
interface contention_controller_if;
   logic       LpTxEn;
   logic       ErrContentionP0;
   logic       ErrContentionP1;
   logic [3:0] CfgBlankCycles;
   logic [3:0] CfgFilterCycles;
   logic [7:0] CfgHoldCycles;
   logic       ErrClear;
   logic       LpDrvDisable;
   logic       ContentionIrq;
   logic       ErrContentionP0Sticky;
   logic       ErrContentionP1Sticky;
   logic [7:0] ContentionCount;
   logic [2:0] State;

   modport master (
      output LpTxEn, ErrContentionP0, ErrContentionP1,
      output CfgBlankCycles, CfgFilterCycles, CfgHoldCycles, ErrClear,
      input  LpDrvDisable, ContentionIrq,
      input  ErrContentionP0Sticky, ErrContentionP1Sticky,
      input  ContentionCount, State
   );

   modport slave (
      input  LpTxEn, ErrContentionP0, ErrContentionP1,
      input  CfgBlankCycles, CfgFilterCycles, CfgHoldCycles, ErrClear,
      output LpDrvDisable, ContentionIrq,
      output ErrContentionP0Sticky, ErrContentionP1Sticky,
      output ContentionCount, State
   );
endinterface

// File: rtl/contention_controller.sv
// LP contention controller: blanking, persistence filter, driver release
// with minimum hold, sticky error flags and saturating event counter.
module contention_controller (
   input logic Clk,
   input logic Rst,
   contention_controller_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BLANK   = 3'd1,
      MONITOR = 3'd2,
      FILTER  = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t     state;
   logic [3:0] blank_cnt;
   logic [3:0] filt_cnt;
   logic [7:0] hold_cnt;
   logic [1:0] pending;
   logic       drv_dis;
   logic       irq;
   logic [1:0] sticky;
   logic [7:0] count;

   logic       trig;
   logic [3:0] eff;
   logic [4:0] filt_nxt;
   logic [4:0] blank_nxt;
   logic [1:0] pend_nxt;
   logic       confirm;
   logic       exit_rel;

   assign trig      = bus.ErrContentionP0 | bus.ErrContentionP1;
   assign eff       = (bus.CfgFilterCycles == 4'd0) ? 4'd1
                                                    : bus.CfgFilterCycles;
   assign filt_nxt  = {1'b0, filt_cnt} + 5'd1;
   assign blank_nxt = {1'b0, blank_cnt} + 5'd1;
   assign pend_nxt  = ((state == FILTER) ? pending : 2'b00)
                    | {bus.ErrContentionP1, bus.ErrContentionP0};

   assign confirm = bus.LpTxEn && trig &&
                    ((state == MONITOR && eff == 4'd1) ||
                     (state == FILTER && filt_nxt >= {1'b0, eff}));

   // Decision uses the post-decrement count so Hold=N gives N release cycles
   assign exit_rel = (state == RELEASE) && (hold_cnt <= 8'd1) && !bus.LpTxEn;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         blank_cnt <= 4'd0;
         filt_cnt  <= 4'd0;
         hold_cnt  <= 8'd0;
         pending   <= 2'b00;
         drv_dis   <= 1'b0;
         irq       <= 1'b0;
         sticky    <= 2'b00;
         count     <= 8'd0;
      end else begin
         irq <= confirm;

         if (confirm) begin
            if (bus.ErrClear) begin
               sticky <= pend_nxt;
               count  <= 8'd1;
            end else begin
               sticky <= sticky | pend_nxt;
               count  <= (count == 8'hff) ? 8'hff : count + 8'd1;
            end
         end else if (bus.ErrClear) begin
            sticky <= 2'b00;
            count  <= 8'd0;
         end

         unique case (state)
            IDLE: begin
               if (bus.LpTxEn) begin
                  blank_cnt <= 4'd0;
                  state     <= (bus.CfgBlankCycles != 4'd0) ? BLANK : MONITOR;
               end
            end
            BLANK: begin
               if (!bus.LpTxEn) begin
                  state     <= IDLE;
                  blank_cnt <= 4'd0;
               end else if (blank_nxt >= {1'b0, bus.CfgBlankCycles}) begin
                  state     <= MONITOR;
                  blank_cnt <= 4'd0;
               end else begin
                  blank_cnt <= blank_nxt[3:0];
               end
            end
            MONITOR: begin
               if (!bus.LpTxEn) begin
                  state <= IDLE;
               end else if (confirm) begin
                  state    <= RELEASE;
                  drv_dis  <= 1'b1;
                  hold_cnt <= bus.CfgHoldCycles;
                  pending  <= 2'b00;
               end else if (trig) begin
                  state    <= FILTER;
                  filt_cnt <= 4'd1;
                  pending  <= pend_nxt;
               end
            end
            FILTER: begin
               if (!bus.LpTxEn || !trig) begin
                  state    <= bus.LpTxEn ? MONITOR : IDLE;
                  filt_cnt <= 4'd0;
                  pending  <= 2'b00;
               end else if (confirm) begin
                  state    <= RELEASE;
                  drv_dis  <= 1'b1;
                  hold_cnt <= bus.CfgHoldCycles;
                  filt_cnt <= 4'd0;
                  pending  <= 2'b00;
               end else begin
                  filt_cnt <= filt_nxt[3:0];
                  pending  <= pend_nxt;
               end
            end
            RELEASE: begin
               if (hold_cnt != 8'd0)
                  hold_cnt <= hold_cnt - 8'd1;
               if (exit_rel) begin
                  state    <= IDLE;
                  drv_dis  <= 1'b0;
                  hold_cnt <= 8'd0;
               end
            end
            default: begin
               state     <= IDLE;
               drv_dis   <= 1'b0;
               blank_cnt <= 4'd0;
               filt_cnt  <= 4'd0;
               hold_cnt  <= 8'd0;
               pending   <= 2'b00;
            end
         endcase
      end
   end

   assign bus.LpDrvDisable          = drv_dis;
   assign bus.ContentionIrq         = irq;
   assign bus.ErrContentionP0Sticky = sticky[0];
   assign bus.ErrContentionP1Sticky = sticky[1];
   assign bus.ContentionCount       = count;
   assign bus.State                 = state;

endmodule
